// File: rtl/mem_arb2_pkg.sv
// Shared memory-subsystem definitions: arbiter state encoding, default
// grant timeout and width of the grant timer.
package mem_arb2_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_GRANT0 = 2'd1,
      ARB_GRANT1 = 2'd2
   } arb_state_e;

   localparam int unsigned MEM_ARB_TIMEOUT_DEFAULT = 64;

   // Wide enough for the largest legal timeout (65535).
   localparam int unsigned MEM_ARB_CNT_W = 16;

endpackage

// File: rtl/mem_arb2.sv
// Two-port round-robin arbiter in front of a single variable-latency memory.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   mN_addr/wdata/wstrb         requester N access attributes (N = 0, 1)
//   mN_read/mN_write            requester N request, held until mN_ready
//   mN_rdata/mN_ready/mN_err    requester N response (ready is a 1-cycle pulse,
//                               err accompanies ready on a timed-out access)
//   mem_addr/wdata/wstrb        shared memory request
//   mem_read/mem_write
//   mem_rdata/mem_ready         memory response
//
// state      | meaning
// -----------+----------------------------------------------------------
// ARB_IDLE   | no grant; mem_* held at 0 so the memory restarts latency
// ARB_GRANT0 | requester 0 owns the memory port
// ARB_GRANT1 | requester 1 owns the memory port
module mem_arb2
   import mem_arb2_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = MEM_ARB_TIMEOUT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,

   input  logic [ADDR_WIDTH-1:0]   m0_addr,
   input  logic [DATA_WIDTH-1:0]   m0_wdata,
   input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
   input  logic                    m0_read,
   input  logic                    m0_write,
   output logic [DATA_WIDTH-1:0]   m0_rdata,
   output logic                    m0_ready,
   output logic                    m0_err,

   input  logic [ADDR_WIDTH-1:0]   m1_addr,
   input  logic [DATA_WIDTH-1:0]   m1_wdata,
   input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
   input  logic                    m1_read,
   input  logic                    m1_write,
   output logic [DATA_WIDTH-1:0]   m1_rdata,
   output logic                    m1_ready,
   output logic                    m1_err,

   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb,
   output logic                    mem_read,
   output logic                    mem_write,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_ready
);

   // Grant timer counts down from TIMEOUT-1; reaching zero without
   // mem_ready is the abort point.
   localparam logic [MEM_ARB_CNT_W-1:0] TMR_LOAD = MEM_ARB_CNT_W'(TIMEOUT - 1);

   arb_state_e                state_q, state_d;
   logic                      ptr_q, ptr_d;     // last port served
   logic [MEM_ARB_CNT_W-1:0]  tmr_q, tmr_d;

   logic req0, req1;
   logic gnt_req;

   always_comb begin
      req0      = m0_read | m0_write;
      req1      = m1_read | m1_write;
      state_d   = state_q;
      ptr_d     = ptr_q;
      tmr_d     = tmr_q;
      gnt_req   = 1'b0;

      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;

      m0_rdata  = '0;
      m0_ready  = 1'b0;
      m0_err    = 1'b0;
      m1_rdata  = '0;
      m1_ready  = 1'b0;
      m1_err    = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            if (req0 && req1) begin
               state_d = ptr_q ? ARB_GRANT0 : ARB_GRANT1;
            end else if (req0) begin
               state_d = ARB_GRANT0;
            end else if (req1) begin
               state_d = ARB_GRANT1;
            end
            // Preloading every idle cycle gives a fresh count on grant entry.
            tmr_d = TMR_LOAD;
         end
         ARB_GRANT0: begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_wstrb = m0_wstrb;
            mem_write = m0_write;
            mem_read  = m0_read & ~m0_write;
            gnt_req   = req0;
         end
         ARB_GRANT1: begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wstrb = m1_wstrb;
            mem_write = m1_write;
            mem_read  = m1_read & ~m1_write;
            gnt_req   = req1;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase

      if (state_q == ARB_GRANT0 || state_q == ARB_GRANT1) begin
         if (!gnt_req) begin
            // Requester withdrew: silent release, pointer untouched.
            state_d = ARB_IDLE;
         end else if (mem_ready || tmr_q == '0) begin
            // mem_ready on the terminal cycle is still a normal completion.
            state_d = ARB_IDLE;
            ptr_d   = (state_q == ARB_GRANT1);
            if (state_q == ARB_GRANT0) begin
               m0_ready = 1'b1;
               m0_err   = ~mem_ready;
               m0_rdata = mem_ready ? mem_rdata : '0;
            end else begin
               m1_ready = 1'b1;
               m1_err   = ~mem_ready;
               m1_rdata = mem_ready ? mem_rdata : '0;
            end
         end else begin
            tmr_d = tmr_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         ptr_q   <= 1'b1;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         tmr_q   <= tmr_d;
      end
   end

endmodule

// File: tb/tb_mem_arb2.sv
// Directed bench for mem_arb2 with a fixed-latency memory model and
// per-port expected-response queues.
module tb_mem_arb2;

   logic        clk;
   logic        rst_n;

   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [3:0]  m0_wstrb;
   logic        m0_read, m0_write, m0_ready, m0_err;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m1_wstrb;
   logic        m1_read, m1_write, m1_ready, m1_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        mem_read, mem_write, mem_ready;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   served[$];

   bit [31:0] ref_mem [64];
   bit [31:0] mem_arr [64];
   logic [7:0] lat_ctr;
   logic [7:0] lat_cfg;
   logic       mem_en;
   logic       force_rdy;
   logic       prev_rdy;

   mem_arb2 dut (
      .clk(clk), .rst_n(rst_n),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_read(m0_read), .m0_write(m0_write),
      .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_read(m1_read), .m1_write(m1_write),
      .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: ready after lat_cfg cycles of continuous request.
   always_comb begin
      mem_ready = force_rdy | (mem_en & (mem_read | mem_write) & (lat_ctr == lat_cfg));
      mem_rdata = (mem_ready & mem_read) ? mem_arr[mem_addr[7:2]] : 32'h0;
   end

   always @(posedge clk) begin
      if (!(mem_read | mem_write) || mem_ready) lat_ctr <= 8'd0;
      else                                      lat_ctr <= lat_ctr + 8'd1;
      if (mem_ready && mem_write) begin
         for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) mem_arr[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Response monitor: pops expectations on each ready pulse.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n) begin
         prev_rdy <= 1'b0;
      end else begin
         if (prev_rdy) check("dead_cycle", 32'(mem_read | mem_write), 32'h0);
         if (m0_ready || m1_ready) check("dual_ready", 32'(m0_ready & m1_ready), 32'h0);
         if (m0_ready) begin
            check("m0_ready_expected", 32'(q0.size() != 0), 32'h1);
            if (q0.size() != 0) begin
               e = q0.pop_front();
               check("m0_rdata", m0_rdata, e.data);
               check("m0_err", 32'(m0_err), 32'(e.err));
               check("m0_mem_addr", mem_addr, e.addr);
               check("m0_mem_write", 32'(mem_write), 32'(e.wr));
               check("m0_mem_read", 32'(mem_read), 32'(!e.wr));
            end
            served.push_back(0);
         end else begin
            check("m0_idle_rdata", m0_rdata, 32'h0);
            check("m0_idle_err", 32'(m0_err), 32'h0);
         end
         if (m1_ready) begin
            check("m1_ready_expected", 32'(q1.size() != 0), 32'h1);
            if (q1.size() != 0) begin
               e = q1.pop_front();
               check("m1_rdata", m1_rdata, e.data);
               check("m1_err", 32'(m1_err), 32'(e.err));
               check("m1_mem_addr", mem_addr, e.addr);
               check("m1_mem_write", 32'(mem_write), 32'(e.wr));
               check("m1_mem_read", 32'(mem_read), 32'(!e.wr));
            end
            served.push_back(1);
         end else begin
            check("m1_idle_rdata", m1_rdata, 32'h0);
            check("m1_idle_err", 32'(m1_err), 32'h0);
         end
         prev_rdy <= m0_ready | m1_ready;
      end
   end

   // One access: push expectation, drive, wait (bounded) for ready, release.
   // lat counts negedges from drive to ready; 1 is the IDLE arbitration cycle.
   task automatic access(input int port, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic exp_err,
                         input logic force_idle, output int lat);
      exp_t e;
      int   n;
      logic got;
      e.wr   = wr;
      e.addr = addr;
      e.err  = exp_err;
      e.data = 32'h0;
      if (!exp_err) begin
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (strb[b]) ref_mem[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
         end else begin
            e.data = ref_mem[addr[7:2]];
         end
      end
      if (port == 0) begin
         q0.push_back(e);
         m0_addr = addr; m0_wdata = wdata; m0_wstrb = strb; m0_read = rd; m0_write = wr;
      end else begin
         q1.push_back(e);
         m1_addr = addr; m1_wdata = wdata; m1_wstrb = strb; m1_read = rd; m1_write = wr;
      end
      if (force_idle) force_rdy = 1'b1;
      n   = 0;
      got = 1'b0;
      while (!got && n < 300) begin
         @(negedge clk);
         n++;
         got = (port == 0) ? m0_ready : m1_ready;
         if (n == 1 && force_idle) begin
            check("idle_mem_ready_ignored", 32'(m0_ready | m1_ready), 32'h0);
            force_rdy = 1'b0;
         end
      end
      check("ready_in_bound", 32'(got), 32'h1);
      lat = n;
      @(posedge clk);
      #1;
      if (port == 0) begin m0_read = 1'b0; m0_write = 1'b0; end
      else           begin m1_read = 1'b0; m1_write = 1'b0; end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int la, lb;
      rst_n = 1'b0;
      m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0; m0_read = 1'b0; m0_write = 1'b0;
      m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0; m1_read = 1'b0; m1_write = 1'b0;
      mem_en = 1'b1; lat_cfg = 8'd5; force_rdy = 1'b0;

      // Reset holds everything quiet even with a request present.
      m0_addr = 32'h10; m0_read = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_read", 32'(mem_read), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_m0_ready", 32'(m0_ready), 32'h0);
      check("rst_m0_rdata", m0_rdata, 32'h0);
      m0_read = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Simultaneous read and write: port 0 wins first tie after reset.
      served.delete();
      fork
         access(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b0, la);
         access(1, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, lb);
      join
      check("tie_count", 32'(served.size()), 32'd2);
      check("tie_first", 32'(served[0]), 32'd0);
      check("tie_second", 32'(served[1]), 32'd1);
      check("tie_lat_m0", 32'(la), 32'd7);
      check("tie_lat_m1", 32'(lb), 32'd14);

      // Readback through port 0 with a stray mem_ready during IDLE.
      access(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b1, la);
      check("readback_lat", 32'(la), 32'd7);
      check("readback_value", ref_mem[16], 32'hDEADBEEF);
      access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, la);
      check("single_read_lat", 32'(la), 32'd7);

      // Continuous contention: strictly alternating grants, port 1 first.
      served.delete();
      fork
         begin
            access(0, 1'b0, 1'b1, 32'h100, 32'h11110000, 4'hF, 1'b0, 1'b0, la);
            access(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, la);
            access(0, 1'b0, 1'b1, 32'h104, 32'h22334455, 4'b0101, 1'b0, 1'b0, la);
            access(0, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 1'b0, 1'b0, la);
         end
         begin
            access(1, 1'b0, 1'b1, 32'h40, 32'h1234CAFE, 4'b0011, 1'b0, 1'b0, lb);
            access(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, lb);
            access(1, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 1'b0, 1'b0, lb);
            access(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, lb);
         end
      join
      check("rr_count", 32'(served.size()), 32'd8);
      check("rr_first", 32'(served[0]), 32'd1);
      for (int i = 1; i < served.size(); i++)
         check("rr_alternate", 32'(served[i] != served[i-1]), 32'h1);

      // Withdrawn request: no ready, pointer unchanged (port 1 wins next tie).
      m0_addr = 32'h1FC;
      m1_addr = 32'h44; m1_read = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("drop_grant_read", 32'(mem_read), 32'h1);
      check("drop_grant_addr", mem_addr, 32'h44);
      @(posedge clk);
      #1 m1_read = 1'b0;
      @(negedge clk);
      check("drop_no_ready", 32'(m1_ready), 32'h0);
      @(posedge clk);
      #1;
      served.delete();
      fork
         access(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, la);
         access(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, lb);
      join
      check("drop_tie_first", 32'(served[0]), 32'd1);
      check("drop_tie_second", 32'(served[1]), 32'd0);

      // Read and write together: write wins.
      access(0, 1'b1, 1'b1, 32'h48, 32'h5A5A5A5A, 4'hF, 1'b0, 1'b0, la);
      access(0, 1'b1, 1'b0, 32'h48, 32'h0, 4'h0, 1'b0, 1'b0, la);

      // Timeout abort.
      mem_en = 1'b0;
      access(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 1'b0, lb);
      check("timeout_lat", 32'(lb), 32'd65);
      mem_en = 1'b1;

      // mem_ready on the terminal cycle, and one cycle before it.
      lat_cfg = 8'd63;
      access(0, 1'b1, 1'b0, 32'h48, 32'h0, 4'h0, 1'b0, 1'b0, la);
      check("edge_ready_lat", 32'(la), 32'd65);
      lat_cfg = 8'd62;
      access(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, lb);
      check("near_edge_lat", 32'(lb), 32'd64);
      lat_cfg = 8'd5;

      // Reset two cycles into a port-0 grant.
      m0_addr = 32'h200; m0_read = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_mem_read", 32'(mem_read), 32'h0);
      check("midrst_m0_ready", 32'(m0_ready), 32'h0);
      check("midrst_m0_err", 32'(m0_err), 32'h0);
      m0_read = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      served.delete();
      fork
         access(0, 1'b1, 1'b0, 32'h48, 32'h0, 4'h0, 1'b0, 1'b0, la);
         access(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, lb);
      join
      check("postrst_first", 32'(served[0]), 32'd0);
      check("postrst_second", 32'(served[1]), 32'd1);
      check("postrst_lat_m0", 32'(la), 32'd7);

      repeat (3) @(posedge clk);
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arb2.md
MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width of all address ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width; strobe width is DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT, default 64, maximum cycles a grant may wait for mem_ready before abort; legal range 2..65535.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 mN_addr / mN_wdata / mN_wstrb  input  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  requester N (N=0,1) address, write data, byte strobes.
REQ-007 mN_read / mN_write  input  1 each  requester N read / write request, held until mN_ready.
REQ-008 mN_rdata  output  DATA_WIDTH  read data to requester N, valid only when mN_ready=1.
REQ-009 mN_ready  output  1  single-cycle completion pulse to requester N.
REQ-010 mN_err  output  1  single-cycle pulse with mN_ready when the access timed out.
REQ-011 mem_addr / mem_wdata / mem_wstrb / mem_read / mem_write  output  as REQ-006/007  shared port to one mem_nzlat instance.
REQ-012 mem_rdata / mem_ready  input  DATA_WIDTH / 1  memory response.

Function
REQ-013 States SHALL be IDLE, GRANT0, GRANT1; state, round-robin pointer and timeout counter are the only registers.
REQ-014 IDLE: if exactly one requester asserts read or write, next state is its GRANT; if both, next state is GRANT of the port not last served (pointer); if none, stay IDLE.
REQ-015 While in IDLE all mem_* request outputs SHALL be 0 (one mandatory dead cycle between grants so the memory restarts its latency count).
REQ-016 In GRANTn, mem_addr/wdata/wstrb/read/write SHALL combinationally equal requester n's inputs; the other requester's inputs are ignored.
REQ-017 If requester n asserts both read and write in GRANTn, mem_write=1 and mem_read=0 (write wins).
REQ-018 In GRANTn, mem_ready=1 SHALL produce mn_ready=1 and mn_rdata=mem_rdata in the same cycle; next state IDLE; pointer set to n.
REQ-019 mN_rdata SHALL be 0 whenever mN_ready=0; the non-granted port's ready, err, rdata are always 0.
REQ-020 Grant latency: request first seen in IDLE at cycle C SHALL appear on mem_* at cycle C+1.
REQ-021 Timeout counter clears on entry to GRANTn and increments each GRANT cycle without mem_ready; when it equals TIMEOUT-1 with no mem_ready, mn_ready=1, mn_err=1, mn_rdata=0 that cycle, next state IDLE, pointer set to n.
REQ-022 mem_ready in the same cycle as the timeout condition SHALL count as normal completion (no err).
REQ-023 If requester n drops both read and write while in GRANTn, next state IDLE with no ready pulse; pointer unchanged.
REQ-024 mem_ready in IDLE SHALL be ignored (no ready to any port).
REQ-025 Back-to-back: a requester holding a new request in the cycle after its ready SHALL be arbitrated normally in IDLE, losing to a waiting other port.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, pointer = 1 (so port 0 wins the first tie), counter 0, all outputs 0.
REQ-027 Reset mid-grant SHALL abandon the access with no ready or err pulse; first grant after release follows REQ-014.

Structure
REQ-028 State enum and a default-TIMEOUT constant SHALL live in the shared memory-subsystem package used by the cache benches.
REQ-029 Single flat module, no sub-modules; one always_ff for registers, combinational mux for mem_* and response routing.

Verification (mem_nzlat READ_LATENCY=5, WRITE_LATENCY=5, TIMEOUT=64)
REQ-030 m0 read addr 0x10 alone at cycle 0 -> mem_read from cycle 1, m0_ready with mem_rdata when mem_ready fires, mem_read 0 the next cycle.
REQ-031 m0 read 0x20 and m1 write 0x40 wdata 0xDEADBEEF wstrb 0xF both at cycle 0 -> m0 granted first, one IDLE cycle, then m1; readback of 0x40 via m0 returns 0xDEADBEEF.
REQ-032 Both ports requesting continuously for 8 accesses -> grants strictly alternate 0,1,0,1,...; no port served twice in a row.
REQ-033 mem_ready tied 0, m1 read -> m1_ready=1 and m1_err=1 exactly 63 cycles after grant start, m1_rdata=0, state IDLE next.
REQ-034 rst_n pulsed low 2 cycles into an m0 grant -> mem_read drops immediately, no m0_ready; after release, simultaneous requests grant m0 first.
